// File: rtl/hex_capture_if.sv
// Scan-side and readback signals of hex_capture, grouped so the display source
// (master) and the capture block (slave) share one bundle.
interface hex_capture_if;
  logic [7:0]  hex_seg;
  logic [3:0]  hex_grid;
  logic        clear;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        seg_err;

  modport master (
    output hex_seg, hex_grid, clear,
    input  value, dp, frame_valid, seg_err
  );

  modport slave (
    input  hex_seg, hex_grid, clear,
    output value, dp, frame_valid, seg_err
  );
endinterface

// File: rtl/hex_capture.sv
// Rebuilds the 16-bit value and decimal points shown by a multiplexed 4-digit
// seven-segment scan, accepting a digit only after it has dwelt STABLE_CYCLES samples.
module hex_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input logic         Clk,
  input logic         Reset_n,
  hex_capture_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [7:0]    s_seg;
  logic [3:0]    s_grid;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [15:0]   stage_nib;
  logic [3:0]    stage_dp;
  logic [3:0]    seen;
  logic [15:0]   value_r;
  logic [3:0]    dp_r;
  logic          frame_valid_r;
  logic          seg_err_r;

  logic [3:0]    sel;
  logic          one_hot;
  logic          same;
  logic          capture;
  logic [6:0]    pat;
  logic [3:0]    dec;
  logic          dec_ok;
  logic [1:0]    idx;
  logic [15:0]   merged_nib;
  logic [3:0]    merged_dp;

  assign sel     = ~bus.hex_grid;
  assign one_hot = (sel != 4'h0) && ((sel & (sel - 4'h1)) == 4'h0);
  assign same    = one_hot && (bus.hex_grid == s_grid) && (bus.hex_seg == s_seg);
  assign pat     = ~bus.hex_seg[6:0];

  // The incoming sample is what s_seg/s_grid hold after this edge, so the capture
  // decision is made on the same edge that completes the dwell.
  always_comb begin
    cnt_next = '0;
    if (same)
      cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
    else if (one_hot)
      cnt_next = CW'(1);
  end

  assign capture = (cnt_next == CNT_MAX) && !(same && (cnt == CNT_MAX));

  always_comb begin
    dec    = 4'h0;
    dec_ok = 1'b1;
    case (pat)
      7'h3F: dec = 4'h0;
      7'h06: dec = 4'h1;
      7'h5B: dec = 4'h2;
      7'h4F: dec = 4'h3;
      7'h66: dec = 4'h4;
      7'h6D: dec = 4'h5;
      7'h7D: dec = 4'h6;
      7'h07: dec = 4'h7;
      7'h7F: dec = 4'h8;
      7'h6F: dec = 4'h9;
      7'h77: dec = 4'hA;
      7'h7C: dec = 4'hB;
      7'h39: dec = 4'hC;
      7'h5E: dec = 4'hD;
      7'h79: dec = 4'hE;
      7'h71: dec = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (sel[i]) idx = 2'(i);
    merged_nib = stage_nib;
    merged_nib[idx*4 +: 4] = dec;
    merged_dp = stage_dp;
    merged_dp[idx] = ~bus.hex_seg[7];
  end

  // Clear takes priority over a coincident capture, which is then dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s_seg         <= 8'hFF;
      s_grid        <= 4'hF;
      cnt           <= '0;
      stage_nib     <= '0;
      stage_dp      <= '0;
      seen          <= '0;
      value_r       <= '0;
      dp_r          <= '0;
      frame_valid_r <= 1'b0;
      seg_err_r     <= 1'b0;
    end else begin
      s_seg         <= bus.hex_seg;
      s_grid        <= bus.hex_grid;
      cnt           <= cnt_next;
      frame_valid_r <= 1'b0;
      if (bus.clear) begin
        seg_err_r <= 1'b0;
        seen      <= '0;
      end else if (capture) begin
        if (!dec_ok) begin
          seg_err_r <= 1'b1;
        end else begin
          stage_nib <= merged_nib;
          stage_dp  <= merged_dp;
          if ((seen | sel) == 4'hF) begin
            value_r       <= merged_nib;
            dp_r          <= merged_dp;
            frame_valid_r <= 1'b1;
            seen          <= '0;
          end else begin
            seen <= seen | sel;
          end
        end
      end
    end
  end

  assign bus.value       = value_r;
  assign bus.dp          = dp_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.seg_err     = seg_err_r;
endmodule

// File: tb/tb_hex_capture.sv
// Directed and randomized scan sequences for hex_capture, checked against a
// dwell-level model of the capture rules.
module tb_hex_capture;
  localparam int S = 4;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  hex_capture_if bus ();

  hex_capture #(.STABLE_CYCLES(S)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_asserts = 0;
  int n_fails   = 0;
  int fv_count  = 0;
  int m_commits = 0;

  logic [3:0]  m_stage [4];
  logic [3:0]  m_sdp;
  logic [3:0]  m_seen;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic        m_err;

  always @(negedge Clk) if (bus.frame_valid === 1'b1) fv_count++;

  function automatic logic [3:0] grid_of(input int d);
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [7:0] seg_of(input int nib, input logic dpv);
    return {~dpv, ~PAT[nib]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_stage[i] = 4'h0;
    m_sdp = 4'h0; m_seen = 4'h0; m_value = 16'h0; m_dp = 4'h0; m_err = 1'b0;
  endtask

  task automatic model_capture(input logic [3:0] grid, input logic [7:0] seg);
    int d = 0;
    int found = -1;
    for (int i = 0; i < 4; i++) if (!grid[i]) d = i;
    for (int k = 0; k < 16; k++) if (PAT[k] == ~seg[6:0]) found = k;
    if (found < 0) begin
      m_err = 1'b1;
    end else begin
      m_stage[d] = 4'(found);
      m_sdp[d]   = ~seg[7];
      m_seen[d]  = 1'b1;
      if (m_seen == 4'hF) begin
        m_value = {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
        m_dp    = m_sdp;
        m_seen  = 4'h0;
        m_commits++;
      end
    end
  endtask

  // One dwell of n samples after a blank: captures iff one-hot and long enough,
  // unless a clear lands on exactly the capturing sample.
  task automatic model_dwell(input logic [3:0] grid, input logic [7:0] seg, input int n, input bit clr);
    if ($countones(~grid) == 1 && n >= S && !(clr && n == S)) model_capture(grid, seg);
    if (clr) begin m_err = 1'b0; m_seen = 4'h0; end
  endtask

  task automatic apply_stimulus(input logic [3:0] grid, input logic [7:0] seg, input int n, input bit clr);
    bus.hex_grid = grid;
    bus.hex_seg  = seg;
    bus.clear    = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (clr && c == n - 1) bus.clear = 1'b1;
      @(negedge Clk);
    end
    bus.clear    = 1'b0;
    bus.hex_grid = 4'hF;
    bus.hex_seg  = 8'hFF;
    @(negedge Clk);
    model_dwell(grid, seg, n, clr);
  endtask

  task automatic clear_pulse();
    bus.clear = 1'b1;
    @(negedge Clk);
    bus.clear = 1'b0;
    m_err = 1'b0; m_seen = 4'h0;
  endtask

  task automatic scan4(input int n0, input int n1, input int n2, input int n3, input logic [3:0] dps);
    apply_stimulus(grid_of(0), seg_of(n0, dps[0]), S, 1'b0);
    apply_stimulus(grid_of(1), seg_of(n1, dps[1]), S, 1'b0);
    apply_stimulus(grid_of(2), seg_of(n2, dps[2]), S, 1'b0);
    apply_stimulus(grid_of(3), seg_of(n3, dps[3]), S, 1'b0);
  endtask

  task automatic check_output(input string tag);
    #1;
    n_asserts++;
    assert (bus.value === m_value) else begin
      n_fails++; $error("[TB] FAIL %s value observed=%h expected=%h", tag, bus.value, m_value);
    end
    n_asserts++;
    assert (bus.dp === m_dp) else begin
      n_fails++; $error("[TB] FAIL %s dp observed=%b expected=%b", tag, bus.dp, m_dp);
    end
    n_asserts++;
    assert (bus.seg_err === m_err) else begin
      n_fails++; $error("[TB] FAIL %s seg_err observed=%b expected=%b", tag, bus.seg_err, m_err);
    end
    n_asserts++;
    assert (bus.frame_valid === 1'b0) else begin
      n_fails++; $error("[TB] FAIL %s frame_valid observed=%b expected=0", tag, bus.frame_valid);
    end
    n_asserts++;
    assert (fv_count == m_commits) else begin
      n_fails++; $error("[TB] FAIL %s pulses observed=%0d expected=%0d", tag, fv_count, m_commits);
    end
  endtask

  initial begin
    logic [3:0] g;
    logic [7:0] sg;
    Reset_n      = 1'b0;
    bus.hex_grid = 4'hF;
    bus.hex_seg  = 8'hFF;
    bus.clear    = 1'b0;
    model_reset();
    check_output("reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;

    scan4(4, 3, 2, 1, 4'b0000);
    check_output("scan_1234");

    for (int d = 0; d < 4; d++) apply_stimulus(grid_of(d), seg_of(5 + d, 1'b0), S - 1, 1'b0);
    check_output("short_dwell");

    apply_stimulus(grid_of(0), seg_of(9, 1'b0), S, 1'b0);
    apply_stimulus(grid_of(1), seg_of(8, 1'b0), S, 1'b0);
    apply_stimulus(grid_of(2), 8'hFF, S, 1'b0);
    apply_stimulus(grid_of(3), seg_of(6, 1'b0), S, 1'b0);
    check_output("bad_digit");
    clear_pulse();
    check_output("clear");
    scan4(9, 8, 7, 6, 4'b0000);
    check_output("rescan");

    apply_stimulus(4'b1100, seg_of(3, 1'b0), 20, 1'b0);
    check_output("ghost");
    scan4(10, 11, 12, 13, 4'b0001);
    check_output("scan_dcba");

    apply_stimulus(grid_of(1), seg_of(5, 1'b0), S, 1'b0);
    apply_stimulus(grid_of(1), seg_of(7, 1'b1), S + 2, 1'b0);
    apply_stimulus(grid_of(0), seg_of(0, 1'b0), S, 1'b0);
    apply_stimulus(grid_of(2), seg_of(2, 1'b0), S, 1'b0);
    apply_stimulus(grid_of(3), seg_of(15, 1'b1), S, 1'b0);
    check_output("recapture");

    apply_stimulus(grid_of(0), seg_of(14, 1'b0), S, 1'b0);
    apply_stimulus(grid_of(1), seg_of(1, 1'b0), S, 1'b0);
    #2 Reset_n = 1'b0;
    model_reset();
    check_output("reset_mid");
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    scan4(6, 5, 4, 3, 4'b1010);
    check_output("post_reset");

    apply_stimulus(grid_of(2), seg_of(1, 1'b0), S, 1'b0);
    apply_stimulus(grid_of(0), seg_of(2, 1'b0), S, 1'b0);
    apply_stimulus(grid_of(1), seg_of(3, 1'b0), S, 1'b0);
    apply_stimulus(grid_of(3), seg_of(4, 1'b0), S, 1'b1);
    check_output("clear_wins");
    scan4(12, 0, 15, 8, 4'b0100);
    check_output("after_clear_wins");

    for (int k = 0; k < 80; k++) begin
      int r;
      r  = $urandom_range(0, 19);
      g  = (r == 0) ? 4'($urandom_range(0, 15)) : grid_of($urandom_range(0, 3));
      sg = (r == 1) ? 8'($urandom) : seg_of($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      apply_stimulus(g, sg, $urandom_range(1, 7), ($urandom_range(0, 9) == 0));
      check_output("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
